hanoi_solver: RTL and testbench
===============================

HANOI_SOLVER -- requirements
Module: hanoi_solver

Interface
REQ-001 The block SHALL have parameter NUM_DISCS, default 20, giving the disc count; the legal range is 1..31.
REQ-002 The block SHALL have parameter DISC_W, default 5, giving the disc-index width; it SHALL satisfy 2^DISC_W > NUM_DISCS.
REQ-003 The ports SHALL be:
  clock  in  1  sole clock; all flops on its rising edge
  reset  in  1  synchronous, active-high reset
  start  in  1  begin/restart a solution run (IDLE or DONE only)
  move_valid  out  1  a move is presented
  move_ready  in  1  the puzzle consumer accepts the move
  move_from  out  2  source peg (Peg: A=0, B=1, C=2)
  move_to  out  2  destination peg
  move_disc  out  DISC_W  index of the disc moved (0 = smallest)
  busy  out  1  a run is in progress
  done  out  1  all discs are on peg B
  move_count  out  NUM_DISCS  count of accepted moves

Function
REQ-004 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-005 IDLE -> RUN SHALL occur on start=1; on that edge the mirror array disc[0..NUM_DISCS-1] SHALL be set to A and move_count to 0.
REQ-006 DONE -> RUN SHALL occur on start=1, with the same initialisation as REQ-005; start SHALL be ignored while in RUN.
REQ-007 move_valid SHALL equal (state==RUN), so the first move is valid the cycle after start is sampled.
REQ-008 A move SHALL transfer only on an edge where move_valid && move_ready; on that edge disc[move_disc] <= move_to and move_count increments.
REQ-009 While move_valid=1 && move_ready=0, move_from, move_to and move_disc SHALL remain stable.
REQ-010 Throughput SHALL be one move per cycle while move_ready is held high.
REQ-011 Odd moves (move_count even, i.e. moves 1, 3, 5, ...) SHALL move disc 0 cyclically: A->B->C->A when NUM_DISCS is odd, A->C->B->A when NUM_DISCS is even.
REQ-012 Even moves SHALL use the two pegs not holding disc 0: the peg with the smaller top disc is the source, the other peg is the destination, and an empty peg's top is NUM_DISCS.
REQ-013 The top disc of a peg SHALL be the lowest index i with disc[i]==peg, else NUM_DISCS.
REQ-014 When the accepted move makes move_count == 2^NUM_DISCS-1, the FSM SHALL enter DONE on that edge.
REQ-015 done SHALL be 1 exactly when every disc[i]==B; busy SHALL equal (state==RUN).
REQ-016 When NUM_DISCS=1, the single move A->B SHALL be followed by DONE.
REQ-017 In IDLE and DONE, move_from, move_to and move_disc SHALL be 0.

Reset
REQ-018 On reset=1 the block SHALL set state=IDLE, all disc[i]=A, move_count=0, move_valid=0, busy=0 and done=0, overriding start and any pending handshake.
REQ-019 A reset asserted in the middle of a run SHALL discard the run, and no move SHALL be accepted on that edge.

Configuration
REQ-020 With HANOI_SOLVER_CHECK_EN defined, the block SHALL add output `illegal` (1 bit, reset 0). `illegal` SHALL set sticky on any accepted move where the source peg is empty or the source top is not smaller than the destination top.
REQ-021 With HANOI_SOLVER_CHECK_EN undefined, the `illegal` port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-022 Package hanoi_pkg SHALL hold the Peg enum (A, B, C) and the default NUM_DISCS constant; the puzzle model and this block SHALL share it.
REQ-023 Sub-module hanoi_top_finder SHALL be a parameterised priority encoder (disc array, peg) -> top index, instantiated once per peg.
REQ-024 All state SHALL be in hanoi_solver, and its outputs SHALL depend only on registered state.

Verification
REQ-025 NUM_DISCS=3, start pulse, move_ready=1 -> moves SHALL be 0:A->B, 1:A->C, 0:B->C, 2:A->B, 0:C->A, 1:C->B, 0:A->B, one per cycle; then done=1, move_valid=0, move_count=7.
REQ-026 NUM_DISCS=2 -> moves SHALL be A->C, A->B, C->B; then done=1, move_count=3.
REQ-027 NUM_DISCS=3, move_ready toggled randomly -> outputs SHALL be stable during stalls, the sequence SHALL match REQ-025, and move_count SHALL equal the number of handshakes.
REQ-028 Reset asserted after 4 accepted moves -> next cycle: state IDLE, move_count=0, all discs A; a new start SHALL reproduce REQ-025 from move 1.
REQ-029 Default NUM_DISCS=20, move_ready=1, driving the hanoi puzzle model -> done SHALL be 1 after exactly 1048575 moves, with illegal=0 throughout (HANOI_SOLVER_CHECK_EN defined).
REQ-030 start pulsed during RUN -> no effect; start in DONE -> discs SHALL return to A and the sequence SHALL restart.

Source files
------------

// File: rtl/hanoi_pkg.sv
// Shared Towers of Hanoi types: peg encoding, solver FSM states, default disc count.
package hanoi_pkg;

  typedef enum logic [1:0] {
    PEG_A = 2'd0,
    PEG_B = 2'd1,
    PEG_C = 2'd2
  } peg_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NUM_DISCS_DEFAULT = 20;

  // Peg arithmetic modulo 3; k is 1 or 2.
  function automatic logic [1:0] peg_add(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/hanoi_top_finder.sv
// Priority encoder: smallest disc index resting on peg_i, or NUM_DISCS when the peg is empty.
// Purely combinational; no flow control.
module hanoi_top_finder
  import hanoi_pkg::*;
#(
  parameter int NUM_DISCS = NUM_DISCS_DEFAULT,
  parameter int DISC_W    = 5
) (
  input  logic [NUM_DISCS-1:0][1:0] discs_i,
  input  logic [1:0]                peg_i,
  output logic [DISC_W-1:0]         top_o
);

  // Scan from the largest index down so the lowest match wins.
  always_comb begin
    top_o = DISC_W'(NUM_DISCS);
    for (int i = NUM_DISCS - 1; i >= 0; i--) begin
      if (discs_i[i] == peg_i) top_o = DISC_W'(i);
    end
  end

endmodule

// File: rtl/hanoi_solver.sv
// Iterative Towers of Hanoi solver (A->B): first move valid 1 cycle after start, one move per cycle,
// move held stable while move_ready is low. HANOI_SOLVER_CHECK_EN adds a sticky `illegal` output.
module hanoi_solver
  import hanoi_pkg::*;
#(
  parameter int NUM_DISCS = NUM_DISCS_DEFAULT,
  parameter int DISC_W    = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 move_valid,
  input  logic                 move_ready,
  output logic [1:0]           move_from,
  output logic [1:0]           move_to,
  output logic [DISC_W-1:0]    move_disc,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_DISCS-1:0] move_count
`ifdef HANOI_SOLVER_CHECK_EN
  ,
  output logic                 illegal
`endif
);

  localparam bit ODD_N = (NUM_DISCS % 2) == 1;

  state_e                    state_q, state_d;
  logic [NUM_DISCS-1:0][1:0] disc_q, disc_d;
  logic [NUM_DISCS-1:0]      cnt_q, cnt_d;
  logic [NUM_DISCS-1:0]      cnt_inc;

  logic [DISC_W-1:0] top_a, top_b, top_c;
  logic [DISC_W-1:0] top_x, top_y, mv_disc;
  logic [1:0]        peg0, peg_x, peg_y, mv_from, mv_to;
  logic              accept, all_on_b;

  function automatic logic [DISC_W-1:0] pick_top(input logic [1:0] p,
                                                 input logic [DISC_W-1:0] ta,
                                                 input logic [DISC_W-1:0] tb,
                                                 input logic [DISC_W-1:0] tc);
    case (p)
      PEG_A:   return ta;
      PEG_B:   return tb;
      default: return tc;
    endcase
  endfunction

  hanoi_top_finder #(.NUM_DISCS(NUM_DISCS), .DISC_W(DISC_W)) u_top_a (
    .discs_i(disc_q), .peg_i(PEG_A), .top_o(top_a)
  );
  hanoi_top_finder #(.NUM_DISCS(NUM_DISCS), .DISC_W(DISC_W)) u_top_b (
    .discs_i(disc_q), .peg_i(PEG_B), .top_o(top_b)
  );
  hanoi_top_finder #(.NUM_DISCS(NUM_DISCS), .DISC_W(DISC_W)) u_top_c (
    .discs_i(disc_q), .peg_i(PEG_C), .top_o(top_c)
  );

  // Even move counts move disc 0 cyclically; odd counts make the only legal move between the other two pegs.
  always_comb begin
    peg0  = disc_q[0];
    peg_x = peg_add(peg0, 2'd1);
    peg_y = peg_add(peg0, 2'd2);
    top_x = pick_top(peg_x, top_a, top_b, top_c);
    top_y = pick_top(peg_y, top_a, top_b, top_c);
    if (!cnt_q[0]) begin
      mv_from = peg0;
      mv_to   = ODD_N ? peg_x : peg_y;
      mv_disc = '0;
    end else if (top_x < top_y) begin
      mv_from = peg_x;
      mv_to   = peg_y;
      mv_disc = top_x;
    end else begin
      mv_from = peg_y;
      mv_to   = peg_x;
      mv_disc = top_y;
    end
  end

  assign accept  = (state_q == ST_RUN) && move_ready;
  assign cnt_inc = cnt_q + NUM_DISCS'(1);

  always_comb begin
    state_d = state_q;
    disc_d  = disc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          disc_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          for (int i = 0; i < NUM_DISCS; i++) begin
            if (mv_disc == DISC_W'(i)) disc_d[i] = mv_to;
          end
          cnt_d = cnt_inc;
          if (&cnt_inc) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      disc_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    all_on_b = 1'b1;
    for (int i = 0; i < NUM_DISCS; i++) begin
      if (disc_q[i] != PEG_B) all_on_b = 1'b0;
    end
  end

  assign move_valid = (state_q == ST_RUN);
  assign busy       = (state_q == ST_RUN);
  assign done       = all_on_b;
  assign move_count = cnt_q;
  assign move_from  = move_valid ? mv_from : 2'd0;
  assign move_to    = move_valid ? mv_to   : 2'd0;
  assign move_disc  = move_valid ? mv_disc : '0;

`ifdef HANOI_SOLVER_CHECK_EN
  logic [DISC_W-1:0] src_top, dst_top;
  logic              illegal_q, illegal_d;

  always_comb begin
    src_top   = pick_top(mv_from, top_a, top_b, top_c);
    dst_top   = pick_top(mv_to, top_a, top_b, top_c);
    illegal_d = illegal_q;
    if (accept && ((src_top == DISC_W'(NUM_DISCS)) || (src_top >= dst_top))) illegal_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_hanoi_solver.sv
// Scoreboard bench for hanoi_solver (3 discs): closed-form reference moves queued, monitor compares handshakes.
module tb_hanoi_solver;

  localparam int N  = 3;
  localparam int DW = 2;

  typedef struct {
    int from;
    int to;
    int disc;
    int idx;
  } mv_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          move_valid;
  logic          move_ready = 1'b0;
  logic [1:0]    move_from, move_to;
  logic [DW-1:0] move_disc;
  logic          busy, done;
  logic [N-1:0]  move_count;
`ifdef HANOI_SOLVER_CHECK_EN
  logic          illegal;
`endif

  int  tests = 0;
  int  fails = 0;
  int  hs_cnt = 0;
  int  valid_cycles = 0;
  int  ready_mode = 0;   // 0: held low, 1: held high, 2: random
  mv_t exp_q[$];

  hanoi_solver #(.NUM_DISCS(N), .DISC_W(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_from  (move_from),
    .move_to    (move_to),
    .move_disc  (move_disc),
    .busy       (busy),
    .done       (done),
    .move_count (move_count)
`ifdef HANOI_SOLVER_CHECK_EN
    ,
    .illegal    (illegal)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Closed-form solution: move k moves disc ctz(k) from (k&(k-1))%3 to ((k|(k-1))+1)%3,
  // which lands the tower on peg 1 for even N; odd N swaps pegs 1 and 2.
  function automatic int swap12(input int p, input bit odd);
    if (!odd) return p;
    if (p == 1) return 2;
    if (p == 2) return 1;
    return p;
  endfunction

  task automatic push_run();
    for (int k = 1; k < (1 << N); k++) begin
      mv_t m;
      int  t;
      m.disc = 0;
      t = k;
      while ((t % 2) == 0) begin
        m.disc++;
        t = t / 2;
      end
      m.from = swap12((k & (k - 1)) % 3, (N % 2) == 1);
      m.to   = swap12(((k | (k - 1)) + 1) % 3, (N % 2) == 1);
      m.idx  = k - 1;
      exp_q.push_back(m);
    end
  endtask

  // Ready driver: changes 1 time unit after each rising edge.
  initial forever begin
    @(posedge clock);
    #1;
    case (ready_mode)
      0:       move_ready = 1'b0;
      1:       move_ready = 1'b1;
      default: move_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: handshake checks against the queue, plus stall stability.
  initial begin
    bit          pv, pr;
    logic [1:0]  pf, pt;
    logic [DW-1:0] pd;
    int          pc;
    pv = 0;
    pr = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pv = 0;
        continue;
      end
      if (move_valid) valid_cycles++;
      if (pv && !pr && move_valid) begin
        chk("stall_from", int'(move_from), int'(pf));
        chk("stall_to",   int'(move_to),   int'(pt));
        chk("stall_disc", int'(move_disc), int'(pd));
        chk("stall_count", int'(move_count), pc);
      end
      if (move_valid && move_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_move", 1, 0);
        end else begin
          mv_t e;
          e = exp_q.pop_front();
          chk("move_from", int'(move_from), e.from);
          chk("move_to",   int'(move_to),   e.to);
          chk("move_disc", int'(move_disc), e.disc);
          chk("move_count_at_hs", int'(move_count), e.idx);
          chk("done_low_in_run", int'(done), 0);
          hs_cnt++;
        end
      end
      pv = move_valid;
      pr = move_ready;
      pf = move_from;
      pt = move_to;
      pd = move_disc;
      pc = int'(move_count);
    end
  end

  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!(done && !move_valid) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic check_finished(input string name);
    @(negedge clock);
    chk({name, "_done"},  int'(done), 1);
    chk({name, "_valid"}, int'(move_valid), 0);
    chk({name, "_busy"},  int'(busy), 0);
    chk({name, "_count"}, int'(move_count), (1 << N) - 1);
    chk({name, "_hs"},    hs_cnt, (1 << N) - 1);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_idle_from"}, int'(move_from), 0);
    chk({name, "_idle_disc"}, int'(move_disc), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_valid", int'(move_valid), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_count", int'(move_count), 0);
    chk("rst_from",  int'(move_from), 0);
    chk("rst_to",    int'(move_to), 0);

    // Run 1: ready held high, check one move per cycle
    ready_mode = 1;
    hs_cnt = 0;
    valid_cycles = 0;
    push_run();
    pulse_start();
    @(negedge clock);
    chk("first_valid_after_start", int'(move_valid), 1);
    chk("busy_in_run", int'(busy), 1);
    wait_done("run1", 100);
    chk("run1_throughput", valid_cycles, (1 << N) - 1);
    check_finished("run1");

    // Run 2: random stalls, restart from DONE, start pulsed mid-run
    ready_mode = 2;
    hs_cnt = 0;
    push_run();
    pulse_start();
    @(negedge clock);
    chk("restart_done_cleared", int'(done), 0);
    chk("restart_count_zero", int'(move_count), 0);
    while (hs_cnt < 3) @(posedge clock);
    pulse_start();
    wait_done("run2", 300);
    check_finished("run2");

    // Run 3: reset after 4 accepted moves
    ready_mode = 1;
    hs_cnt = 0;
    push_run();
    pulse_start();
    begin
      int n;
      n = 0;
      while (hs_cnt < 4 && n < 100) begin
        @(posedge clock);
        n++;
      end
      if (n >= 100) chk("reset_wait_timeout", 1, 0);
    end
    #1 reset = 1'b1;
    @(negedge clock);
    chk("pre_reset_count", int'(move_count), 4);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_count", int'(move_count), 0);
    chk("midrst_valid", int'(move_valid), 0);
    chk("midrst_busy",  int'(busy), 0);
    chk("midrst_done",  int'(done), 0);
    exp_q.delete();

    // Run 4: fresh run after reset reproduces the sequence from move 1
    ready_mode = 2;
    hs_cnt = 0;
    push_run();
    pulse_start();
    wait_done("run4", 300);
    check_finished("run4");

`ifdef HANOI_SOLVER_CHECK_EN
    chk("illegal_never_set", int'(illegal), 0);
`endif

    ready_mode = 0;
    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
